// File: rtl/load_align_if.sv
// Load path bus between the execute/memory side and load_align_unit.
// master: issue and read-port side (drives load metadata and memory data).
// slave:  load_align_unit (returns the aligned value to writeback).
interface load_align_if #(
   parameter int XLEN = 32
);
   logic            ld_valid;
   logic [XLEN-1:0] ld_addr;
   logic [2:0]      ld_funct3;
   logic            stall;
   logic [XLEN-1:0] dmem_dout;
   logic [XLEN-1:0] io_dout;
   logic [XLEN-1:0] dmem_lex;
   logic [3:0]      bios_dmem;
   logic            wb_valid;
   logic            misalign;

   modport master (
      output ld_valid, ld_addr, ld_funct3, stall, dmem_dout, io_dout,
      input  dmem_lex, bios_dmem, wb_valid, misalign
   );

   modport slave (
      input  ld_valid, ld_addr, ld_funct3, stall, dmem_dout, io_dout,
      output dmem_lex, bios_dmem, wb_valid, misalign
   );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: memory-to-writeback load path.
// Captures load metadata at issue, then extracts and sign/zero-extends the
// byte/half/word returned one cycle later by DMEM or MMIO. While the pipeline
// is stalled the result is frozen in hold_q so writeback sees a stable value.
// Optional feature macro: LOAD_MISALIGN_CHECK_EN (flags misaligned LH/LHU/LW
// and forces the load value to zero for them).
module load_align_unit #(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   load_align_if.slave   bus
);

   typedef enum logic {
      RUN  = 1'b0,
      HELD = 1'b1
   } state_t;

   // Load metadata captured at issue
   logic            valid_q;
   logic [2:0]      funct3_q;
   logic [1:0]      off_q;
   logic [3:0]      region_q;

   // Hold path
   state_t          state_q;
   state_t          state_d;
   logic            capture;
   logic [XLEN-1:0] hold_q;

   logic [XLEN-1:0] src_word;
   logic [XLEN-1:0] live_lex;
   logic            live_mis;

   // Byte/half selection and extension; undefined funct3 yields zero.
   function automatic logic [XLEN-1:0] extract(
      input logic [XLEN-1:0] word,
      input logic [2:0]      f3,
      input logic [1:0]      off
   );
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [XLEN-1:0]    r;
      b = word[8*off +: 8];
      h = word[16*off[1] +: 16];
      case (f3)
         3'b000:  r = {{(XLEN-8){b[7]}}, b};
         3'b001:  r = {{(XLEN-16){h[15]}}, h};
         3'b010:  r = word;
         3'b100:  r = {{(XLEN-8){1'b0}}, b};
         3'b101:  r = {{(XLEN-16){1'b0}}, h};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Misalignment: half on odd byte, word on any non-zero offset.
   function automatic logic is_misaligned(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      logic r;
      case (f3)
         3'b001, 3'b101: r = off[0];
         3'b010:         r = (off != 2'b00);
         default:        r = 1'b0;
      endcase
      return r;
   endfunction

   // Issue-stage metadata register; frozen during a stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         funct3_q <= 3'b000;
         off_q    <= 2'b00;
         region_q <= 4'b0000;
      end else if (!bus.stall) begin
         valid_q  <= bus.ld_valid;
         funct3_q <= bus.ld_funct3;
         off_q    <= bus.ld_addr[1:0];
         region_q <= bus.ld_addr[XLEN-1 -: 4];
      end
   end

   // MMIO region selects io_dout; BIOS and DMEM both extract from dmem_dout.
   assign src_word = (region_q == 4'b1000) ? bus.io_dout : bus.dmem_dout;

`ifdef LOAD_MISALIGN_CHECK_EN
   logic mis_hold_q;

   assign live_mis = valid_q & is_misaligned(funct3_q, off_q);
   assign live_lex = (!valid_q || live_mis) ? '0 : extract(src_word, funct3_q, off_q);

   // Misalign flag is frozen alongside the held result.
   always_ff @(posedge clk) begin
      if (!rst_n)
         mis_hold_q <= 1'b0;
      else if (capture)
         mis_hold_q <= live_mis;
   end

   assign bus.misalign = (state_q == HELD) ? mis_hold_q : live_mis;
`else
   assign live_mis     = 1'b0;
   assign live_lex     = valid_q ? extract(src_word, funct3_q, off_q) : '0;
   assign bus.misalign = live_mis;
`endif

   // Hold FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   // Hold FSM next state: freeze a valid result when a stall begins,
   // release on the first non-stalled edge.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.stall && valid_q) begin
               state_d = HELD;
               capture = 1'b1;
            end
         end
         HELD: begin
            if (!bus.stall)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Held copy of the live extraction, taken on stall entry.
   always_ff @(posedge clk) begin
      if (!rst_n)
         hold_q <= '0;
      else if (capture)
         hold_q <= live_lex;
   end

   assign bus.dmem_lex  = (state_q == HELD) ? hold_q : live_lex;
   assign bus.wb_valid  = valid_q;
   assign bus.bios_dmem = region_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed testbench for load_align_unit: reset, extraction, stall hold,
// back-to-back loads, misalignment and reset during a stall.
module tb_load_align_unit;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   load_align_if #(.XLEN(32)) bus ();

   load_align_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] addr, input logic [2:0] f3,
                        input logic st, input logic [31:0] dm, input logic [31:0] io);
      bus.ld_valid  = v;
      bus.ld_addr   = addr;
      bus.ld_funct3 = f3;
      bus.stall     = st;
      bus.dmem_dout = dm;
      bus.io_dout   = io;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      clk   = 1'b0;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b1, 32'h1000_0003, 3'b000, 1'b0, 32'h80FF_0102, 32'h0);

      // Reset held three cycles with a load presented
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("rst_lex",  bus.dmem_lex,           32'h0);
         chk("rst_wb",   {31'b0, bus.wb_valid},  32'h0);
         chk("rst_bios", {28'b0, bus.bios_dmem}, 32'h0);
      end

      // Release; outputs stay zero this cycle; issue LB
      tick(); rst_n = 1'b1;
      drive(1'b1, 32'h1000_0003, 3'b000, 1'b0, 32'h80FF_0102, 32'h0);
      chk("post_rst_lex", bus.dmem_lex,          32'h0);
      chk("post_rst_wb",  {31'b0, bus.wb_valid}, 32'h0);
      chk("post_rst_mis", {31'b0, bus.misalign}, 32'h0);

      // LB result; issue LBU
      tick(); drive(1'b1, 32'h1000_0003, 3'b100, 1'b0, 32'h80FF_0102, 32'h0);
      chk("lb",      bus.dmem_lex,           32'hFFFF_FF80);
      chk("lb_bios", {28'b0, bus.bios_dmem}, 32'h1);
      chk("lb_wb",   {31'b0, bus.wb_valid},  32'h1);

      // LBU result; issue LH
      tick(); drive(1'b1, 32'h1000_0002, 3'b001, 1'b0, 32'h80FF_0102, 32'h0);
      chk("lbu", bus.dmem_lex, 32'h0000_0080);

      // LH result; issue LHU
      tick(); drive(1'b1, 32'h1000_0002, 3'b101, 1'b0, 32'h8001_7FFF, 32'h0);
      chk("lh", bus.dmem_lex, 32'hFFFF_8001);

      // LHU result; issue LW to MMIO
      tick(); drive(1'b1, 32'h8000_0000, 3'b010, 1'b0, 32'h8001_7FFF, 32'h0);
      chk("lhu", bus.dmem_lex, 32'h0000_8001);

      // LW from io_dout
      tick(); drive(1'b0, 32'h0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
      chk("lw_io",      bus.dmem_lex,           32'h1234_5678);
      chk("lw_io_bios", {28'b0, bus.bios_dmem}, 32'h8);

      // Stall with nothing in flight: no capture, no valid
      tick(); drive(1'b0, 32'h0, 3'b000, 1'b1, 32'h5555_5555, 32'h0);
      chk("idle_stall_wb",  {31'b0, bus.wb_valid}, 32'h0);
      chk("idle_stall_lex", bus.dmem_lex,          32'h0);

      // Issue LW (stall dropped)
      tick(); drive(1'b1, 32'h0000_0100, 3'b010, 1'b0, 32'h5555_5555, 32'h0);
      chk("pre_lw_wb", {31'b0, bus.wb_valid}, 32'h0);

      // N+1: stall rises, live output
      tick(); drive(1'b0, 32'h0, 3'b000, 1'b1, 32'hDEAD_BEEF, 32'h0);
      chk("stall_n1",    bus.dmem_lex,          32'hDEAD_BEEF);
      chk("stall_n1_wb", {31'b0, bus.wb_valid}, 32'h1);

      // N+2..N+4: held while memory port reads zero
      for (int i = 0; i < 3; i++) begin
         tick(); drive(1'b0, 32'h0, 3'b000, 1'b1, 32'h0, 32'h0);
         chk("stall_held",    bus.dmem_lex,          32'hDEAD_BEEF);
         chk("stall_held_wb", {31'b0, bus.wb_valid}, 32'h1);
      end

      // Stall drops: this cycle still shows the held value; issue LB
      tick(); drive(1'b1, 32'h0000_0001, 3'b000, 1'b0, 32'h0, 32'h0);
      chk("stall_release", bus.dmem_lex, 32'hDEAD_BEEF);

      // Back-to-back: LB result, issue LH
      tick(); drive(1'b1, 32'h0000_0000, 3'b001, 1'b0, 32'h0000_7F00, 32'h0);
      chk("b2b_lb",    bus.dmem_lex,          32'h0000_007F);
      chk("b2b_lb_wb", {31'b0, bus.wb_valid}, 32'h1);

      // LH result, issue LW
      tick(); drive(1'b1, 32'h0000_0004, 3'b010, 1'b0, 32'h1234_F00D, 32'h0);
      chk("b2b_lh",    bus.dmem_lex,          32'hFFFF_F00D);
      chk("b2b_lh_wb", {31'b0, bus.wb_valid}, 32'h1);

      // LW result, issue misaligned LW
      tick(); drive(1'b1, 32'h1000_0001, 3'b010, 1'b0, 32'hCAFE_BABE, 32'h0);
      chk("b2b_lw",    bus.dmem_lex,          32'hCAFE_BABE);
      chk("b2b_lw_wb", {31'b0, bus.wb_valid}, 32'h1);

      // Misaligned LW result; issue misaligned LH
      tick(); drive(1'b1, 32'h1000_0003, 3'b001, 1'b0, 32'hA5A5_5A5A, 32'h0);
`ifdef LOAD_MISALIGN_CHECK_EN
      chk("mis_lw_lex", bus.dmem_lex,          32'h0);
      chk("mis_lw_flg", {31'b0, bus.misalign}, 32'h1);
`else
      chk("mis_lw_lex", bus.dmem_lex,          32'hA5A5_5A5A);
      chk("mis_lw_flg", {31'b0, bus.misalign}, 32'h0);
`endif

      // Misaligned LH result; issue undefined funct3
      tick(); drive(1'b1, 32'h0000_0000, 3'b011, 1'b0, 32'h8001_7FFF, 32'h0);
`ifdef LOAD_MISALIGN_CHECK_EN
      chk("mis_lh_lex", bus.dmem_lex,          32'h0);
      chk("mis_lh_flg", {31'b0, bus.misalign}, 32'h1);
`else
      chk("mis_lh_lex", bus.dmem_lex,          32'hFFFF_8001);
      chk("mis_lh_flg", {31'b0, bus.misalign}, 32'h0);
`endif

      // Undefined funct3 yields zero; issue LW for reset-in-stall case
      tick(); drive(1'b1, 32'h0000_0000, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h0);
      chk("undef_f3",    bus.dmem_lex,          32'h0);
      chk("undef_f3_wb", {31'b0, bus.wb_valid}, 32'h1);

      // Stall with LW in flight
      tick(); drive(1'b0, 32'h0, 3'b000, 1'b1, 32'h1111_1111, 32'h0);
      chk("rs_live", bus.dmem_lex, 32'h1111_1111);

      // Held; assert reset on this edge
      tick(); drive(1'b0, 32'h0, 3'b000, 1'b1, 32'h0, 32'h0);
      chk("rs_held", bus.dmem_lex, 32'h1111_1111);
      rst_n = 1'b0;

      // After reset: load dropped, back in RUN; issue LW
      tick(); rst_n = 1'b1;
      drive(1'b1, 32'h0000_0000, 3'b010, 1'b0, 32'h2222_2222, 32'h0);
      chk("rs_wb",  {31'b0, bus.wb_valid}, 32'h0);
      chk("rs_lex", bus.dmem_lex,          32'h0);

      // Fresh load proves the FSM left HELD
      tick(); drive(1'b0, 32'h0, 3'b000, 1'b0, 32'h3333_3333, 32'h0);
      chk("rs_run",    bus.dmem_lex,          32'h3333_3333);
      chk("rs_run_wb", {31'b0, bus.wb_valid}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Memory-to-writeback load path for the 3-stage RISC-V core. Captures load metadata (funct3, byte offset, address region) at issue, then extracts and sign/zero-extends the byte, half or word returned one cycle later by the synchronous DMEM or MMIO read port. It drives the extended load value and the region nibble consumed by the writeback selector. It holds its result stable across pipeline stalls so writeback never sees a changing read port.

## Interface
Parameters:
- `XLEN`, 32: data/address width.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ld_valid`  in  1  load issued this cycle (execute stage).
- `ld_addr`  in  XLEN  effective load address.
- `ld_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `stall`  in  1  pipeline freeze; metadata and result hold while high.
- `dmem_dout`  in  XLEN  DMEM synchronous read data, valid one cycle after issue.
- `io_dout`  in  XLEN  MMIO read data, same timing.
- `dmem_lex`  out  XLEN  aligned, extended load value.
- `bios_dmem`  out  4  registered `ld_addr[31:28]` of the in-flight load.
- `wb_valid`  out  1  `dmem_lex` corresponds to a load this cycle.
- `misalign`  out  1  in-flight load is misaligned (see Configuration).

## Operation
- Metadata register (`valid_q`, `funct3_q`, `off_q`=addr[1:0], `region_q`=addr[31:28]) loads from the issue inputs on every edge with `stall`=0. It holds when `stall`=1.
- Source word: `io_dout` when `region_q`=4'b1000, else `dmem_dout`. When `region_q`=4'b0100 (BIOS), the writeback selector uses its own BIOS port; `dmem_lex` is still computed from `dmem_dout` but ignored downstream.
- Extraction:
  - Byte is `word[8*off_q +: 8]`; half is `word[16*off_q[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Undefined funct3 (011, 110, 111) gives 0.
- Hold state machine, states RUN and HELD:
  - RUN: output = live extraction. On a cycle with `stall`=1 and `valid_q`=1, capture the live extraction into `hold_q` and go to HELD on the next edge.
  - HELD: output = `hold_q`. Go to RUN on the first edge with `stall`=0; that cycle still outputs `hold_q`.
- `wb_valid` = `valid_q`; `bios_dmem` = `region_q`.
- Reset: all registers 0, state RUN. While and after reset, `dmem_lex`=0, `bios_dmem`=0, `wb_valid`=0, `misalign`=0.

## Timing
- Latency: a load issued in cycle N with `stall`=0 produces `dmem_lex` combinationally in cycle N+1 from `dmem_dout`/`io_dout`.
- No extra register on the data path in RUN. In HELD the output is registered.
- Back-to-back loads N, N+1: each result is valid in the following cycle; no bubble.
- Stall arriving in N+1: the N+1 output is live. From N+2 until stall drops, the output is the captured value, even if the memory port changes.
- Stall with `valid_q`=0: no capture; state stays RUN; `wb_valid`=0.
- A load presented while `stall`=1 is not sampled; the issuer must re-present it.
- `rst_n` low mid-stall or mid-load: state goes to RUN on that edge; the in-flight load is dropped (`wb_valid`=0 next cycle).

## Configuration
- `LOAD_MISALIGN_CHECK_EN` defined:
  - `misalign` = `valid_q` & ((LH/LHU & `off_q[0]`) | (LW & `off_q`≠0)).
  - When `misalign`=1, `dmem_lex` is forced to 0.
  - `misalign` is captured and held with the result in HELD.
- Not defined: `misalign` is tied 0 and extraction proceeds as above. A misaligned half uses `off_q[1]` only; a misaligned LW returns the aligned word.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `ld_valid`=1 -> `dmem_lex`=0, `wb_valid`=0, `bios_dmem`=0 throughout, and for one cycle after release.
- LB at addr 0x1000_0003, `dmem_dout`=0x80FF_0102 -> next cycle `dmem_lex`=0xFFFF_FF80, `bios_dmem`=4'b0001. LBU at the same address -> 0x0000_0080.
- LH at 0x1000_0002, `dmem_dout`=0x8001_7FFF -> 0xFFFF_8001. LHU at the same address -> 0x0000_8001. LW at 0x8000_0000 with `io_dout`=0x1234_5678 -> 0x1234_5678.
- Stall hold: LW issued, `dmem_dout`=0xDEAD_BEEF in N+1. `stall`=1 for N+1..N+4 while `dmem_dout` changes to 0 -> `dmem_lex`=0xDEAD_BEEF on N+1..N+4; back to RUN after stall drops.
- Back-to-back LB/LH/LW with `stall`=0 -> three consecutive correct results, `wb_valid` high for 3 cycles.
- Misaligned LW at 0x1000_0001: with `LOAD_MISALIGN_CHECK_EN` -> `misalign`=1, `dmem_lex`=0. Without it -> `misalign`=0, `dmem_lex`=`dmem_dout`.
